// File: rtl/fixed_weight_loc_gen_pkg.sv
// Shared HQC parameter-set constants used by the sparse multiplier and the
// fixed-weight location generator, plus a small weight saturation helper.
package fixed_weight_loc_gen_pkg;

  localparam int unsigned HQC_RAND_WIDTH = 32;

  localparam int unsigned HQC128_N          = 17669;
  localparam int unsigned HQC128_M          = 15;
  localparam int unsigned HQC128_WEIGHT     = 66;
  localparam int unsigned HQC128_MAX_WEIGHT = 75;

  localparam int unsigned HQC192_N          = 35851;
  localparam int unsigned HQC192_M          = 16;
  localparam int unsigned HQC192_WEIGHT     = 100;
  localparam int unsigned HQC192_MAX_WEIGHT = 114;

  localparam int unsigned HQC256_N          = 57637;
  localparam int unsigned HQC256_M          = 16;
  localparam int unsigned HQC256_WEIGHT     = 131;
  localparam int unsigned HQC256_MAX_WEIGHT = 149;

  localparam int unsigned HQC128_LOG_MAX_WEIGHT = $clog2(HQC128_MAX_WEIGHT);
  localparam int unsigned HQC192_LOG_MAX_WEIGHT = $clog2(HQC192_MAX_WEIGHT);
  localparam int unsigned HQC256_LOG_MAX_WEIGHT = $clog2(HQC256_MAX_WEIGHT);

  // Clamp a requested weight to the location RAM depth.
  function automatic int unsigned sat_weight(input int unsigned w, input int unsigned max_w);
    return (w > max_w) ? max_w : w;
  endfunction

endpackage

// File: rtl/fixed_weight_loc_gen_if.sv
// Control, random-stream and location read-port bundle of the location
// generator.
//   master: start/weight, rand_in/rand_valid, loc_rd_addr (driver side)
//   slave : rand_ready, loc_rd_data, busy, done (generator side)
interface fixed_weight_loc_gen_if #(
  parameter int unsigned M              = fixed_weight_loc_gen_pkg::HQC128_M,
  parameter int unsigned LOG_MAX_WEIGHT = fixed_weight_loc_gen_pkg::HQC128_LOG_MAX_WEIGHT,
  parameter int unsigned RAND_WIDTH     = fixed_weight_loc_gen_pkg::HQC_RAND_WIDTH
);

  logic                      start;
  logic [LOG_MAX_WEIGHT-1:0] weight;
  logic [RAND_WIDTH-1:0]     rand_in;
  logic                      rand_valid;
  logic                      rand_ready;
  logic [LOG_MAX_WEIGHT-1:0] loc_rd_addr;
  logic [M-1:0]              loc_rd_data;
  logic                      busy;
  logic                      done;

  modport master (
    output start, weight, rand_in, rand_valid, loc_rd_addr,
    input  rand_ready, loc_rd_data, busy, done
  );

  modport slave (
    input  start, weight, rand_in, rand_valid, loc_rd_addr,
    output rand_ready, loc_rd_data, busy, done
  );

endinterface

// File: rtl/fixed_weight_loc_gen_mem.sv
// Single-port location RAM with a registered read port (1-cycle latency).
// Contents are never cleared; only the read register is reset.
//   clk, rst : clock, async active-high reset of the read register
//   we       : write enable for addr/wdata
//   addr     : shared read/write address
//   rdata    : registered read data of addr
module fixed_weight_loc_gen_mem
  import fixed_weight_loc_gen_pkg::*;
#(
  parameter int unsigned WIDTH = HQC128_M,
  parameter int unsigned DEPTH = HQC128_MAX_WEIGHT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;
  logic             in_range_c;

  // Addresses past the last word read as zero and ignore writes.
  assign in_range_c = ({1'b0, addr} < (AW+1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (we && in_range_c) begin
      mem_q[addr] <= wdata;
    end
  end

  always_comb begin
    rdata_d = '0;
    if (in_range_c) begin
      rdata_d = mem_q[addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fixed_weight_loc_gen.sv
// Fixed-weight support generator for the HQC sparse multiplier operand.
// Draws M-bit candidates from a random word stream, rejects values >= N and
// duplicates of already stored positions, and stores the accepted positions
// in acceptance order in a location RAM whose read port feeds the multiplier.
//   clk, rst : clock, async active-high reset
//   bus      : start/weight in, rand_in/rand_valid/rand_ready stream,
//              loc_rd_addr/loc_rd_data read port, busy/done status
module fixed_weight_loc_gen
  import fixed_weight_loc_gen_pkg::*;
#(
  parameter int unsigned N          = HQC128_N,
  parameter int unsigned M          = HQC128_M,
  parameter int unsigned MAX_WEIGHT = HQC128_MAX_WEIGHT,
  parameter int unsigned RAND_WIDTH = HQC_RAND_WIDTH
) (
  input logic                   clk,
  input logic                   rst,
  fixed_weight_loc_gen_if.slave bus
);

  localparam int unsigned LOG_MAX_WEIGHT = $clog2(MAX_WEIGHT);
  localparam int unsigned LW             = LOG_MAX_WEIGHT;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CHECK,
    ST_WRITE,
    ST_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [LW-1:0]   w_q, w_d;
  logic [LW-1:0]   count_q, count_d;
  logic [LW-1:0]   scan_q, scan_d;
  logic [M-1:0]    cand_q, cand_d;
  logic            rd_pend_q, rd_pend_d;
  logic            rand_ready_q, rand_ready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [M-1:0]    cand_c;
  logic            cand_ok_c;
  logic            xfer_c;
  logic [LW-1:0]   weight_sat_c;
  logic            mem_we_c;
  logic [LW-1:0]   int_addr_c;
  logic [LW-1:0]   mem_addr_c;
  logic [M-1:0]    mem_rdata;

  assign cand_c       = bus.rand_in[M-1:0];
  assign cand_ok_c    = ({1'b0, cand_c} < (M+1)'(N));
  assign xfer_c       = bus.rand_valid && rand_ready_q;
  assign weight_sat_c = LW'(sat_weight(32'(bus.weight), MAX_WEIGHT));

  // Upper random bits carry no information for the candidate.
  if (RAND_WIDTH > M) begin : g_rand_hi
    logic unused_rand_hi;
    assign unused_rand_hi = ^bus.rand_in[RAND_WIDTH-1:M];
  end

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    w_d        = w_q;
    count_d    = count_q;
    scan_d     = scan_q;
    cand_d     = cand_q;
    rd_pend_d  = 1'b0;
    mem_we_c   = 1'b0;
    int_addr_c = scan_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          w_d     = weight_sat_c;
          count_d = '0;
          state_d = (weight_sat_c == '0) ? ST_DONE : ST_FETCH;
        end
      end

      ST_FETCH: begin
        if (xfer_c && cand_ok_c) begin
          cand_d  = cand_c;
          scan_d  = '0;
          state_d = (count_q == '0) ? ST_WRITE : ST_CHECK;
        end
      end

      // One read issued per cycle; each result is compared the cycle after.
      ST_CHECK: begin
        if (rd_pend_q && (mem_rdata == cand_q)) begin
          state_d = ST_FETCH;
        end else if (scan_q < count_q) begin
          scan_d    = scan_q + LW'(1);
          rd_pend_d = 1'b1;
        end else begin
          state_d = ST_WRITE;
        end
      end

      ST_WRITE: begin
        mem_we_c   = 1'b1;
        int_addr_c = count_q;
        count_d    = count_q + LW'(1);
        state_d    = ((count_q + LW'(1)) == w_q) ? ST_DONE : ST_FETCH;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status outputs are registered images of the next state.
    rand_ready_d = (state_d == ST_FETCH);
    busy_d       = (state_d != ST_IDLE);
    done_d       = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      w_q          <= '0;
      count_q      <= '0;
      scan_q       <= '0;
      cand_q       <= '0;
      rd_pend_q    <= 1'b0;
      rand_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      w_q          <= w_d;
      count_q      <= count_d;
      scan_q       <= scan_d;
      cand_q       <= cand_d;
      rd_pend_q    <= rd_pend_d;
      rand_ready_q <= rand_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // The generator owns the RAM port while busy; otherwise the multiplier does.
  assign mem_addr_c = busy_q ? int_addr_c : bus.loc_rd_addr;

  fixed_weight_loc_gen_mem #(
    .WIDTH (M),
    .DEPTH (MAX_WEIGHT)
  ) u_loc_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we_c),
    .addr  (mem_addr_c),
    .wdata (cand_q),
    .rdata (mem_rdata)
  );

  assign bus.rand_ready  = rand_ready_q;
  assign bus.loc_rd_data = mem_rdata;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule
